// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic MIPS pipeline-stage registers.
// The state encoding matches the {main_v, skid_v} occupancy flags.
package pipe_pkg;

    // Encoded as {main_v, skid_v}. The value 2'b01 cannot occur because skid_v implies main_v.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b10,
        SKID  = 2'b11
    } stage_state_e;

    // Control-field widths (RegWrite/MemRead/MemWrite/MemtoReg-style bits) at each boundary.
    localparam int IFID_CTRL_W  = 1;
    localparam int IDEX_CTRL_W  = 5;
    localparam int EXMEM_CTRL_W = 4;
    localparam int MEMWB_CTRL_W = 2;

    // Data-field widths.
    // IF/ID  : PC+4 and the instruction word.
    // ID/EX  : PC+4, rs and rt operands, and the rt/rd register indices.
    // EX/MEM : ALU result, store data and the destination index.
    // MEM/WB : load data, ALU result and the destination index.
    localparam int IFID_DATA_W  = 32 + 32;
    localparam int IDEX_DATA_W  = 32 + 32 + 32 + 5 + 5;
    localparam int EXMEM_DATA_W = 32 + 32 + 5;
    localparam int MEMWB_DATA_W = 32 + 32 + 5;

    localparam int STALL_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: it counts up once per clock while inc is high and sticks at all-ones.
// Only reset clears it.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (inc && (count_reg != CNT_MAX)) begin
            count_next = count_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a two-entry skid buffer, flush and a stall counter.
// Outputs come straight from the main-entry flops, and in_ready is a flop that does not depend on out_ready.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W,
    parameter int CNT_W  = STALL_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_state_e      state_reg,     state_next;
    logic              in_ready_reg,  in_ready_next;
    logic [CTRL_W-1:0] main_ctrl_reg, main_ctrl_next;
    logic [DATA_W-1:0] main_data_reg, main_data_next;
    logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
    logic [DATA_W-1:0] skid_data_reg, skid_data_next;

    logic main_v;
    logic accept;
    logic release_main;

    assign main_v       = (state_reg != EMPTY);
    assign accept       = in_valid & in_ready_reg;
    assign release_main = main_v & out_ready;

    always_comb begin
        state_next     = state_reg;
        main_ctrl_next = main_ctrl_reg;
        main_data_next = main_data_reg;
        skid_ctrl_next = skid_ctrl_reg;
        skid_data_next = skid_data_reg;

        if (flush) begin
            // Drop every held entry and any accept in this cycle. The data fields keep their old contents.
            state_next     = EMPTY;
            main_ctrl_next = '0;
            skid_ctrl_next = '0;
        end else begin
            unique case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_next     = FULL;
                        main_ctrl_next = in_ctrl;
                        main_data_next = in_data;
                    end
                end
                FULL: begin
                    if (accept && release_main) begin
                        main_ctrl_next = in_ctrl;
                        main_data_next = in_data;
                    end else if (accept) begin
                        state_next     = SKID;
                        skid_ctrl_next = in_ctrl;
                        skid_data_next = in_data;
                    end else if (release_main) begin
                        state_next     = EMPTY;
                        main_ctrl_next = '0;
                    end
                end
                SKID: begin
                    // in_ready is low here, so only a release can happen.
                    if (release_main) begin
                        state_next     = FULL;
                        main_ctrl_next = skid_ctrl_reg;
                        main_data_next = skid_data_reg;
                        skid_ctrl_next = '0;
                    end
                end
                default: begin
                    state_next     = EMPTY;
                    main_ctrl_next = '0;
                    skid_ctrl_next = '0;
                end
            endcase
        end

        in_ready_next = (state_next != SKID);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= EMPTY;
            in_ready_reg  <= 1'b1;
            main_ctrl_reg <= '0;
            main_data_reg <= '0;
            skid_ctrl_reg <= '0;
            skid_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= in_ready_next;
            main_ctrl_reg <= main_ctrl_next;
            main_data_reg <= main_data_next;
            skid_ctrl_reg <= skid_ctrl_next;
            skid_data_reg <= skid_data_next;
        end
    end

    // Gate each control bit with main_v so that out_ctrl is 0 whenever no entry is presented.
    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_gate
            assign out_ctrl[gi] = main_ctrl_reg[gi] & main_v;
        end
    endgenerate

    assign out_valid = main_v;
    assign out_data  = main_data_reg;
    assign in_ready  = in_ready_reg;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (main_v & ~out_ready),
        .count (stall_cnt)
    );

endmodule
